// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I opcode constants and forward-select encoding
package core_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_X  = 2'd1,
    FWD_W  = 2'd2
  } fwd_sel_e;

  // X stage is the youngest producer, so it wins over W.
  function automatic fwd_sel_e fwd_pick(input logic x_hit, input logic w_hit);
    if (x_hit) return FWD_X;
    if (w_hit) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/instr_reg_use.sv
// rtl/instr_reg_use.sv - register-use decode of one RV32I instruction
// Combinational: which source registers are read, whether rd is written, and load detection.
module instr_reg_use
  import core_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        reads_rs1_o,
  output logic        reads_rs2_o,
  output logic        writes_rd_o,
  output logic        is_load_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o
);

  logic [6:0] opcode;
  logic       unused_bits;

  assign opcode      = instr_i[6:0];
  assign rs1_o       = instr_i[19:15];
  assign rs2_o       = instr_i[24:20];
  assign rd_o        = instr_i[11:7];
  assign is_load_o   = (opcode == OP_LOAD);
  assign unused_bits = ^{instr_i[31:25], instr_i[13:12]};

  always_comb begin
    reads_rs1_o = 1'b1;
    reads_rs2_o = 1'b0;
    writes_rd_o = 1'b1;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: reads_rs1_o = 1'b0;
      // CSR immediate forms carry a zimm in the rs1 field
      OP_SYSTEM: reads_rs1_o = ~instr_i[14];
      OP_OP:     reads_rs2_o = 1'b1;
      OP_STORE, OP_BRANCH: begin
        reads_rs2_o = 1'b1;
        writes_rd_o = 1'b0;
      end
      default: ;
    endcase
    if (rd_o == 5'd0) writes_rd_o = 1'b0;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - hazard, stall and forwarding control for the D->X->W core
// Tracks X/W destination registers, drives operand selects, load-use stalls, flushes and freezes.
module hazard_fwd_ctrl
  import core_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_D,
  input  logic              instr_valid_D,
  input  logic              branch_taken_X,
  input  logic              mem_stall,
  output logic [1:0]        rs1_sel,
  output logic [1:0]        rs2_sel,
  output logic              stall_FD,
  output logic              bubble_X,
  output logic              wb_wen,
  output logic [REG_AW-1:0] wb_waddr
);

  localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALL - 1);

  logic              x_valid_q, x_valid_d, x_wen_q, x_wen_d, x_load_q, x_load_d;
  logic [REG_AW-1:0] x_rd_q, x_rd_d;
  logic              w_valid_q, w_valid_d, w_wen_q, w_wen_d;
  logic [REG_AW-1:0] w_rd_q, w_rd_d;
  logic [1:0]        stall_cnt_q, stall_cnt_d;

  logic       reads_rs1, reads_rs2, writes_rd, is_load;
  logic [4:0] rs1, rs2, rd;

  instr_reg_use u_dec (
    .instr_i     (instr_D),
    .reads_rs1_o (reads_rs1),
    .reads_rs2_o (reads_rs2),
    .writes_rd_o (writes_rd),
    .is_load_o   (is_load),
    .rs1_o       (rs1),
    .rs2_o       (rs2),
    .rd_o        (rd)
  );

  logic x_fwd_ok, w_fwd_ok, hz, lu_stall;
  logic x_hit1, x_hit2, w_hit1, w_hit2;

  assign x_fwd_ok = x_valid_q & x_wen_q;
  assign w_fwd_ok = w_valid_q & w_wen_q;

  // A taken branch kills D, so the hazard it would raise never exists.
  assign hz = instr_valid_D & ~branch_taken_X & x_valid_q & x_load_q & x_wen_q &
              ((reads_rs1 & (x_rd_q == REG_AW'(rs1))) |
               (reads_rs2 & (x_rd_q == REG_AW'(rs2))));
  assign lu_stall = ~branch_taken_X & (hz | (stall_cnt_q != 2'd0));

  assign x_hit1 = (rs1 != 5'd0) & x_fwd_ok & (x_rd_q == REG_AW'(rs1)) & ~lu_stall;
  assign x_hit2 = (rs2 != 5'd0) & x_fwd_ok & (x_rd_q == REG_AW'(rs2)) & ~lu_stall;
  assign w_hit1 = (rs1 != 5'd0) & w_fwd_ok & (w_rd_q == REG_AW'(rs1));
  assign w_hit2 = (rs2 != 5'd0) & w_fwd_ok & (w_rd_q == REG_AW'(rs2));

  assign rs1_sel  = fwd_pick(x_hit1, w_hit1);
  assign rs2_sel  = fwd_pick(x_hit2, w_hit2);
  assign wb_wen   = w_fwd_ok & ~mem_stall;
  assign wb_waddr = w_rd_q;

  always_comb begin
    stall_FD = 1'b0;
    bubble_X = 1'b0;
    if (mem_stall) begin
      stall_FD = 1'b1;
    end else if (branch_taken_X) begin
      bubble_X = 1'b1;
    end else if (lu_stall) begin
      stall_FD = 1'b1;
      bubble_X = 1'b1;
    end
  end

  always_comb begin
    x_valid_d   = x_valid_q;
    x_wen_d     = x_wen_q;
    x_load_d    = x_load_q;
    x_rd_d      = x_rd_q;
    w_valid_d   = w_valid_q;
    w_wen_d     = w_wen_q;
    w_rd_d      = w_rd_q;
    stall_cnt_d = stall_cnt_q;
    if (!mem_stall) begin
      w_valid_d = x_valid_q;
      w_wen_d   = x_wen_q;
      w_rd_d    = x_rd_q;
      x_valid_d = instr_valid_D & ~bubble_X & ~branch_taken_X;
      x_wen_d   = writes_rd;
      x_load_d  = is_load;
      x_rd_d    = REG_AW'(rd);
      if (branch_taken_X)            stall_cnt_d = 2'd0;
      else if (stall_cnt_q != 2'd0)  stall_cnt_d = stall_cnt_q - 2'd1;
      else if (hz)                   stall_cnt_d = STALL_INIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_valid_q   <= 1'b0;
      x_wen_q     <= 1'b0;
      x_load_q    <= 1'b0;
      x_rd_q      <= '0;
      w_valid_q   <= 1'b0;
      w_wen_q     <= 1'b0;
      w_rd_q      <= '0;
      stall_cnt_q <= 2'd0;
    end else begin
      x_valid_q   <= x_valid_d;
      x_wen_q     <= x_wen_d;
      x_load_q    <= x_load_d;
      x_rd_q      <= x_rd_d;
      w_valid_q   <= w_valid_d;
      w_wen_q     <= w_wen_d;
      w_rd_q      <= w_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
